// File: rtl/rf_sched_pkg.sv
// Shared types and sizing for the register-file access scheduler.
package rf_sched_pkg;

   localparam int unsigned NUM_SREG = 6;
   localparam int unsigned NUM_VREG = 6;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned VDATA_W  = 192;

   typedef enum logic {SCALAR = 1'b0, VECTOR = 1'b1} reg_kind_e;

   typedef enum logic [1:0] {
      SS   = 2'b00,
      SV   = 2'b01,
      NONE = 2'b10,
      VV   = 2'b11
   } rd_type_e;

   function automatic logic addr_ok(logic [ADDR_W-1:0] addr, reg_kind_e kind);
      return 32'(addr) < ((kind == VECTOR) ? NUM_VREG : NUM_SREG);
   endfunction

endpackage

// File: rtl/rf_access_scheduler_if.sv
// Decode issue, write requesters and register-file pins of the scheduler.
interface rf_access_scheduler_if;
   import rf_sched_pkg::*;

   logic               rd_valid;
   logic               rd_ready;
   logic [ADDR_W-1:0]  rd_a1;
   logic [ADDR_W-1:0]  rd_a2;
   logic [1:0]         rd_type;
   logic               rd_dst_en;
   logic [ADDR_W-1:0]  rd_dst_addr;
   logic               rd_dst_type;
   logic               rd_data_valid;

   logic               wb_valid;
   logic               wb_ready;
   logic [ADDR_W-1:0]  wb_addr;
   logic               wb_type;
   logic [VDATA_W-1:0] wb_data;

   logic               ld_valid;
   logic               ld_ready;
   logic [ADDR_W-1:0]  ld_addr;
   logic               ld_type;
   logic [VDATA_W-1:0] ld_data;

   logic [ADDR_W-1:0]  rf_a1;
   logic [ADDR_W-1:0]  rf_a2;
   logic [ADDR_W-1:0]  rf_a3;
   logic               rf_read;
   logic               rf_write;
   logic [1:0]         rf_regtype;
   logic               rf_destype;
   logic [VDATA_W-1:0] rf_wd;

   modport slave (
      input  rd_valid, rd_a1, rd_a2, rd_type, rd_dst_en, rd_dst_addr, rd_dst_type,
      input  wb_valid, wb_addr, wb_type, wb_data,
      input  ld_valid, ld_addr, ld_type, ld_data,
      output rd_ready, rd_data_valid, wb_ready, ld_ready,
      output rf_a1, rf_a2, rf_a3, rf_read, rf_write, rf_regtype, rf_destype, rf_wd
   );

   modport master (
      output rd_valid, rd_a1, rd_a2, rd_type, rd_dst_en, rd_dst_addr, rd_dst_type,
      output wb_valid, wb_addr, wb_type, wb_data,
      output ld_valid, ld_addr, ld_type, ld_data,
      input  rd_ready, rd_data_valid, wb_ready, ld_ready,
      input  rf_a1, rf_a2, rf_a3, rf_read, rf_write, rf_regtype, rf_destype, rf_wd
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-destination bits for scalar and vector registers plus RAW/WAW lookup.
module rf_scoreboard
   import rf_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              set_i,
   input  reg_kind_e         set_kind_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_i,
   input  reg_kind_e         clr_kind_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  rd_type_e          chk_type_i,
   input  logic [ADDR_W-1:0] chk_a1_i,
   input  logic [ADDR_W-1:0] chk_a2_i,
   input  logic              chk_dst_en_i,
   input  reg_kind_e         chk_dst_kind_i,
   input  logic [ADDR_W-1:0] chk_dst_addr_i,
   output logic              hazard_o
);

   logic [NUM_SREG-1:0] sb_s_q, sb_s_d;
   logic [NUM_VREG-1:0] sb_v_q, sb_v_d;

   function automatic logic is_pending(logic [NUM_SREG-1:0] s, logic [NUM_VREG-1:0] v,
                                       reg_kind_e kind, logic [ADDR_W-1:0] addr);
      logic hit;
      hit = 1'b0;
      if (kind == VECTOR) begin
         for (int unsigned i = 0; i < NUM_VREG; i++) if (addr == ADDR_W'(i)) hit = v[i];
      end else begin
         for (int unsigned i = 0; i < NUM_SREG; i++) if (addr == ADDR_W'(i)) hit = s[i];
      end
      return hit;
   endfunction

   logic      src_used;
   reg_kind_e src1_kind, src2_kind;

   always_comb begin
      src_used  = (chk_type_i != NONE);
      src1_kind = (chk_type_i == VV) ? VECTOR : SCALAR;
      src2_kind = (chk_type_i == VV || chk_type_i == SV) ? VECTOR : SCALAR;
      // Lookup uses registered bits, so a same-cycle clear still stalls.
      hazard_o  = (src_used && is_pending(sb_s_q, sb_v_q, src1_kind, chk_a1_i))
               || (src_used && is_pending(sb_s_q, sb_v_q, src2_kind, chk_a2_i))
               || (chk_dst_en_i && is_pending(sb_s_q, sb_v_q, chk_dst_kind_i, chk_dst_addr_i));
   end

   always_comb begin
      sb_s_d = sb_s_q;
      sb_v_d = sb_v_q;
      if (flush_i) begin
         sb_s_d = '0;
         sb_v_d = '0;
      end else begin
         // Clear first, then set, so a set always wins on the same register.
         for (int unsigned i = 0; i < NUM_SREG; i++) begin
            if (clr_i && clr_kind_i == SCALAR && clr_addr_i == ADDR_W'(i)) sb_s_d[i] = 1'b0;
            if (set_i && set_kind_i == SCALAR && set_addr_i == ADDR_W'(i)) sb_s_d[i] = 1'b1;
         end
         for (int unsigned i = 0; i < NUM_VREG; i++) begin
            if (clr_i && clr_kind_i == VECTOR && clr_addr_i == ADDR_W'(i)) sb_v_d[i] = 1'b0;
            if (set_i && set_kind_i == VECTOR && set_addr_i == ADDR_W'(i)) sb_v_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sb_s_q <= '0;
         sb_v_q <= '0;
      end else begin
         sb_s_q <= sb_s_d;
         sb_v_q <= sb_v_d;
      end
   end

endmodule

// File: rtl/rf_access_scheduler.sv
// Register-file access scheduler: hazard-gated read issue and round-robin write port.
module rf_access_scheduler
   import rf_sched_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   rf_access_scheduler_if.slave bus_io,
   output logic                 addr_err_o
);

   typedef enum logic {RrWb = 1'b0, RrLd = 1'b1} rr_e;

   rr_e  rr_q, rr_d;
   logic data_valid_q, addr_err_q, addr_err_d;

   rd_type_e          rd_type;
   reg_kind_e         src1_kind, src2_kind, dst_kind;
   logic              src_used, rd_oor, hazard, rd_accept;
   logic              grant_wb, grant_ld, granted, w_ok, wr_en;
   logic [ADDR_W-1:0] w_addr;
   reg_kind_e         w_kind;
   logic [VDATA_W-1:0] w_data;

   always_comb begin
      rd_type   = rd_type_e'(bus_io.rd_type);
      src_used  = (rd_type != NONE);
      src1_kind = (rd_type == VV) ? VECTOR : SCALAR;
      src2_kind = (rd_type == VV || rd_type == SV) ? VECTOR : SCALAR;
      dst_kind  = reg_kind_e'(bus_io.rd_dst_type);
      rd_oor    = (src_used && (!addr_ok(bus_io.rd_a1, src1_kind)
                             || !addr_ok(bus_io.rd_a2, src2_kind)))
               || (bus_io.rd_dst_en && !addr_ok(bus_io.rd_dst_addr, dst_kind));
      rd_accept = !rst_i && !flush_i && bus_io.rd_valid && !rd_oor && !hazard;
   end

   rf_scoreboard u_sb (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .set_i          (rd_accept && bus_io.rd_dst_en),
      .set_kind_i     (dst_kind),
      .set_addr_i     (bus_io.rd_dst_addr),
      .clr_i          (wr_en),
      .clr_kind_i     (w_kind),
      .clr_addr_i     (w_addr),
      .chk_type_i     (rd_type),
      .chk_a1_i       (bus_io.rd_a1),
      .chk_a2_i       (bus_io.rd_a2),
      .chk_dst_en_i   (bus_io.rd_dst_en),
      .chk_dst_kind_i (dst_kind),
      .chk_dst_addr_i (bus_io.rd_dst_addr),
      .hazard_o       (hazard)
   );

   // Pointer only moves when both requesters contend.
   always_comb begin
      grant_wb = 1'b0;
      grant_ld = 1'b0;
      rr_d     = rr_q;
      if (!rst_i) begin
         if (bus_io.wb_valid && bus_io.ld_valid) begin
            grant_wb = (rr_q == RrWb);
            grant_ld = (rr_q == RrLd);
            rr_d     = (rr_q == RrWb) ? RrLd : RrWb;
         end else begin
            grant_wb = bus_io.wb_valid;
            grant_ld = bus_io.ld_valid;
         end
      end
      granted = grant_wb || grant_ld;
      w_addr  = grant_ld ? bus_io.ld_addr : bus_io.wb_addr;
      w_kind  = reg_kind_e'(grant_ld ? bus_io.ld_type : bus_io.wb_type);
      w_data  = grant_ld ? bus_io.ld_data : bus_io.wb_data;
      w_ok    = addr_ok(w_addr, w_kind);
      wr_en   = granted && w_ok;
   end

   always_comb begin
      addr_err_d = addr_err_q
                || (!rst_i && bus_io.rd_valid && rd_oor)
                || (granted && !w_ok);
   end

   always_comb begin
      bus_io.rd_ready      = rd_accept;
      bus_io.rd_data_valid = data_valid_q;
      bus_io.wb_ready      = grant_wb;
      bus_io.ld_ready      = grant_ld;
      bus_io.rf_read       = rd_accept;
      bus_io.rf_a1         = rd_accept ? bus_io.rd_a1 : '0;
      bus_io.rf_a2         = rd_accept ? bus_io.rd_a2 : '0;
      bus_io.rf_regtype    = rd_accept ? bus_io.rd_type : 2'b00;
      bus_io.rf_write      = wr_en;
      bus_io.rf_a3         = wr_en ? w_addr : '0;
      bus_io.rf_destype    = wr_en ? logic'(w_kind) : 1'b0;
      bus_io.rf_wd         = wr_en ? w_data : '0;
      addr_err_o           = addr_err_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q         <= RrWb;
         data_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         rr_q         <= rr_d;
         data_valid_q <= rd_accept;
         addr_err_q   <= addr_err_d;
      end
   end

endmodule

// File: tb/tb_rf_access_scheduler.sv
// Directed and random stimulus for rf_access_scheduler checked against a pending-set model.
module tb_rf_access_scheduler;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic addr_err;

   rf_access_scheduler_if bus ();

   rf_access_scheduler dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .bus_io     (bus),
      .addr_err_o (addr_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: pending registers, round-robin turn (0 = wb), read-valid, sticky error
   bit [5:0] m_s;
   bit [5:0] m_v;
   bit       m_rr;
   bit       m_dv;
   bit       m_err;

   task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pend(bit vec, int a);
      if (a >= 6) return 1'b0;
      return vec ? m_v[a] : m_s[a];
   endfunction

   function automatic logic [191:0] rand192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle();
      bus.rd_valid    = 1'b0;
      bus.rd_a1       = '0;
      bus.rd_a2       = '0;
      bus.rd_type     = 2'b10;
      bus.rd_dst_en   = 1'b0;
      bus.rd_dst_addr = '0;
      bus.rd_dst_type = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.wb_addr     = '0;
      bus.wb_type     = 1'b0;
      bus.wb_data     = '0;
      bus.ld_valid    = 1'b0;
      bus.ld_addr     = '0;
      bus.ld_type     = 1'b0;
      bus.ld_data     = '0;
   endtask

   task automatic issue(int a1, int a2, int t, bit den, int dst, bit dty);
      bus.rd_valid    = 1'b1;
      bus.rd_a1       = 4'(a1);
      bus.rd_a2       = 4'(a2);
      bus.rd_type     = 2'(t);
      bus.rd_dst_en   = den;
      bus.rd_dst_addr = 4'(dst);
      bus.rd_dst_type = dty;
   endtask

   task automatic wb_req(int a, bit ty, logic [191:0] d);
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 4'(a);
      bus.wb_type  = ty;
      bus.wb_data  = d;
   endtask

   task automatic ld_req(int a, bit ty, logic [191:0] d);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 4'(a);
      bus.ld_type  = ty;
      bus.ld_data  = d;
   endtask

   // Called just after a negedge with inputs driven; returns at the next negedge.
   task automatic cycle();
      int t, a1, a2, dst, wa;
      bit used, k1, k2, oor, haz, exp_rd, exp_wb, exp_ld, exp_wr, wty;
      logic [191:0] wd;
      #1;
      chk("data_valid", 192'(bus.rd_data_valid), 192'(m_dv));
      chk("addr_err",   192'(addr_err),          192'(m_err));
      chk("sb_s",       192'(dut.u_sb.sb_s_q),   192'(m_s));
      chk("sb_v",       192'(dut.u_sb.sb_v_q),   192'(m_v));
      chk("rr_ptr",     192'(dut.rr_q),          192'(m_rr));

      t    = int'(bus.rd_type);
      a1   = int'(bus.rd_a1);
      a2   = int'(bus.rd_a2);
      dst  = int'(bus.rd_dst_addr);
      used = (t != 2);
      k1   = (t == 3);
      k2   = (t == 1) || (t == 3);
      oor  = (used && (a1 >= 6 || a2 >= 6)) || (bus.rd_dst_en && dst >= 6);
      haz  = (used && (pend(k1, a1) || pend(k2, a2))) || (bus.rd_dst_en && pend(bus.rd_dst_type, dst));
      exp_rd = !rst && !flush && bus.rd_valid && !oor && !haz;

      exp_wb = 1'b0;
      exp_ld = 1'b0;
      if (!rst) begin
         if (bus.wb_valid && bus.ld_valid) begin
            exp_wb = !m_rr;
            exp_ld = m_rr;
         end else begin
            exp_wb = bus.wb_valid;
            exp_ld = bus.ld_valid;
         end
      end
      wa     = exp_ld ? int'(bus.ld_addr) : int'(bus.wb_addr);
      wty    = exp_ld ? bus.ld_type : bus.wb_type;
      wd     = exp_ld ? bus.ld_data : bus.wb_data;
      exp_wr = (exp_wb || exp_ld) && wa < 6;

      chk("rd_ready",   192'(bus.rd_ready),   192'(exp_rd));
      chk("rf_read",    192'(bus.rf_read),    192'(exp_rd));
      chk("rf_a1",      192'(bus.rf_a1),      exp_rd ? 192'(a1) : 192'(0));
      chk("rf_a2",      192'(bus.rf_a2),      exp_rd ? 192'(a2) : 192'(0));
      chk("rf_regtype", 192'(bus.rf_regtype), exp_rd ? 192'(t) : 192'(0));
      chk("wb_ready",   192'(bus.wb_ready),   192'(exp_wb));
      chk("ld_ready",   192'(bus.ld_ready),   192'(exp_ld));
      chk("rf_write",   192'(bus.rf_write),   192'(exp_wr));
      chk("rf_a3",      192'(bus.rf_a3),      exp_wr ? 192'(wa) : 192'(0));
      chk("rf_destype", 192'(bus.rf_destype), exp_wr ? 192'(wty) : 192'(0));
      chk("rf_wd",      bus.rf_wd,            exp_wr ? wd : 192'(0));

      if (rst) begin
         m_s = '0; m_v = '0; m_rr = 1'b0; m_dv = 1'b0; m_err = 1'b0;
      end else begin
         m_dv = exp_rd;
         if (bus.rd_valid && oor) m_err = 1'b1;
         if ((exp_wb || exp_ld) && wa >= 6) m_err = 1'b1;
         if (flush) begin
            m_s = '0;
            m_v = '0;
         end else begin
            if (exp_wr) begin
               if (wty) m_v[wa] = 1'b0;
               else     m_s[wa] = 1'b0;
            end
            if (exp_rd && bus.rd_dst_en) begin
               if (bus.rd_dst_type) m_v[dst] = 1'b1;
               else                 m_s[dst] = 1'b1;
            end
         end
         if (bus.wb_valid && bus.ld_valid) m_rr = !m_rr;
      end
      @(negedge clk);
   endtask

   function automatic int rnd_addr();
      return ($urandom_range(0, 19) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
   endfunction

   initial begin
      idle();
      rst   = 1'b1;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      m_s = '0; m_v = '0; m_rr = 1'b0; m_dv = 1'b0; m_err = 1'b0;
      cycle();
      rst = 1'b0;

      // Basic issue: s2,s3 -> s4
      issue(2, 3, 0, 1'b1, 4, 1'b0);
      cycle();
      idle();
      cycle();
      chk("s4_pending", 192'(dut.u_sb.sb_s_q[4]), 192'(1));

      // RAW on s4; clear in same cycle still stalls
      issue(4, 0, 0, 1'b0, 0, 1'b0);
      cycle();
      wb_req(4, 1'b0, 192'hA5);
      cycle();
      bus.wb_valid = 1'b0;
      cycle();
      idle();
      chk("s4_cleared", 192'(dut.u_sb.sb_s_q[4]), 192'(0));

      // Contended writes alternate; lone ld granted every cycle
      wb_req(1, 1'b0, rand192());
      ld_req(2, 1'b1, rand192());
      repeat (4) cycle();
      bus.wb_valid = 1'b0;
      repeat (3) cycle();
      idle();

      // WAW on v1
      issue(0, 0, 2, 1'b1, 1, 1'b1);
      cycle();
      repeat (2) cycle();
      ld_req(1, 1'b1, rand192());
      cycle();
      bus.ld_valid = 1'b0;
      cycle();
      idle();
      chk("v1_pending", 192'(dut.u_sb.sb_v_q[1]), 192'(1));
      ld_req(1, 1'b1, rand192());
      cycle();
      idle();

      // Out-of-range issue and write
      issue(7, 0, 0, 1'b0, 0, 1'b0);
      cycle();
      idle();
      cycle();
      chk("addr_err_sticky", 192'(addr_err), 192'(1));
      wb_req(9, 1'b0, rand192());
      cycle();
      idle();

      // Flush clears s0 and v5
      issue(0, 0, 2, 1'b1, 0, 1'b0);
      cycle();
      issue(0, 0, 2, 1'b1, 5, 1'b1);
      cycle();
      idle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      chk("flush_clear", 192'({dut.u_sb.sb_s_q, dut.u_sb.sb_v_q}), 192'(0));

      // Reset during contended write
      wb_req(1, 1'b0, rand192());
      ld_req(2, 1'b0, rand192());
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      idle();
      cycle();
      chk("rr_after_rst", 192'(dut.rr_q), 192'(0));

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         idle();
         rst   = ($urandom_range(0, 59) == 0);
         flush = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 9) < 7)
            issue(rnd_addr(), rnd_addr(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_addr(), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1)
            wb_req(rnd_addr(), 1'($urandom_range(0, 1)), rand192());
         if ($urandom_range(0, 1) == 1)
            ld_req(rnd_addr(), 1'($urandom_range(0, 1)), rand192());
         cycle();
      end
      rst   = 1'b0;
      flush = 1'b0;
      idle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
